// File: rtl/cla_serial_adder_ctrl_pkg.sv
// Shared definitions for the serial CLA add/subtract sequencer.
package cla_ctrl_pkg;
   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/cla_serial_adder_ctrl_if.sv
// Requester-side bundle for the serial CLA sequencer.
// start is sampled only while idle or done; busy marks RUN; done is a one-cycle result-valid pulse.
interface cla_serial_adder_ctrl_if
   import cla_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
);
   localparam int W = NIBBLE_W * NIBBLES;

   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   state_t       dbg_state;

   modport master (output start, sub, cin, a, b,
                   input  busy, done, sum, cout, ovf, dbg_state);
   modport slave  (input  start, sub, cin, a, b,
                   output busy, done, sum, cout, ovf, dbg_state);
endinterface

// File: rtl/cla_serial_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice with fully flattened carries.
module cla4_slice (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       c3in
);
   logic [3:0] g;
   logic [3:0] p;
   logic       c1, c2, c3;

   assign g = x & y;
   assign p = x ^ y;

   assign c1 = g[0] | (p[0] & ci);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s    = p ^ {c3, c2, c1, ci};
   assign c3in = c3;
endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// Wide add/subtract sequenced one nibble per cycle through a single CLA slice, LSB nibble first.
module cla_serial_adder_ctrl
   import cla_ctrl_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input logic                    clk,
   input logic                    rst,
   cla_serial_adder_ctrl_if.slave bus
);
   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int CW = $clog2(NIBBLES);

   state_t        state;
   logic [W-1:0]  areg, breg, sum_q;
   logic          creg, cout_q, ovf_q, busy_q, done_q;
   logic [CW-1:0] cnt;
   logic [3:0]    slice_s;
   logic          slice_co, slice_c3;

   cla4_slice u_slice (
      .x    (areg[3:0]),
      .y    (breg[3:0]),
      .ci   (creg),
      .s    (slice_s),
      .co   (slice_co),
      .c3in (slice_c3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         areg   <= '0;
         breg   <= '0;
         creg   <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  // Subtract is a + ~b + 1, so the inversion happens once at capture.
                  state  <= ST_RUN;
                  busy_q <= 1'b1;
                  areg   <= bus.a;
                  breg   <= bus.sub ? ~bus.b : bus.b;
                  creg   <= bus.sub | bus.cin;
                  cnt    <= '0;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_q <= {slice_s, sum_q[W-1:NIBBLE_W]};
               creg  <= slice_co;
               areg  <= areg >> NIBBLE_W;
               breg  <= breg >> NIBBLE_W;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(NIBBLES - 1)) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cout_q <= slice_co;
                  ovf_q  <= slice_c3 ^ slice_co;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Scoreboard bench for the serial CLA sequencer at NIBBLES=4 and NIBBLES=2.
module tb_cla_serial_adder_ctrl;
   import cla_ctrl_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   cla_serial_adder_ctrl_if #(.NIBBLES(4)) if4 ();
   cla_serial_adder_ctrl_if #(.NIBBLES(2)) if2 ();

   cla_serial_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
   cla_serial_adder_ctrl #(.NIBBLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   int n_checks = 0;
   int n_pass   = 0;

   logic [17:0] exp_q4[$];
   logic [17:0] exp_q2[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // behavioural W-bit reference: returns {ovf, cout, sum}
   function automatic logic [17:0] model(input int w, input logic s, input logic c,
                                         input logic [15:0] x, input logic [15:0] y);
      logic [31:0] mask, lmask, bb, full, low;
      logic        ci, co, cm;
      mask  = (32'd1 << w) - 32'd1;
      lmask = (32'd1 << (w - 1)) - 32'd1;
      bb    = (s ? ~{16'h0, y} : {16'h0, y}) & mask;
      ci    = s ? 1'b1 : c;
      full  = ({16'h0, x} & mask) + bb + 32'(ci);
      low   = ({16'h0, x} & lmask) + (bb & lmask) + 32'(ci);
      co    = full[w];
      cm    = low[w-1];
      return {cm ^ co, co, full[15:0] & mask[15:0]};
   endfunction

   // monitors: pop on done
   always @(negedge clk) begin
      logic [17:0] e;
      if (if4.busy && if4.done) check_eq("busy_done_excl4", 1, 0);
      if (if4.done) begin
         if (exp_q4.size() == 0) check_eq("unexpected_done4", 1, 0);
         else begin
            e = exp_q4.pop_front();
            check_eq("sum4",  64'(if4.sum), 64'(e[15:0]));
            check_eq("cout4", 64'(if4.cout), 64'(e[16]));
            check_eq("ovf4",  64'(if4.ovf), 64'(e[17]));
         end
      end
   end

   always @(negedge clk) begin
      logic [17:0] e;
      if (if2.busy && if2.done) check_eq("busy_done_excl2", 1, 0);
      if (if2.done) begin
         if (exp_q2.size() == 0) check_eq("unexpected_done2", 1, 0);
         else begin
            e = exp_q2.pop_front();
            check_eq("sum2",  64'(if2.sum), 64'(e[7:0]));
            check_eq("cout2", 64'(if2.cout), 64'(e[16]));
            check_eq("ovf2",  64'(if2.ovf), 64'(e[17]));
         end
      end
   end

   // driver: poke 0 = none, 1 = start pulse with new operands mid-run, 2 = toggle a/b each cycle
   task automatic op4(input int poke, input logic s, input logic c,
                      input logic [15:0] x, input logic [15:0] y, input logic [17:0] exp);
      int t0, nbusy;
      bit seen;
      @(negedge clk);
      if4.start = 1'b1; if4.sub = s; if4.cin = c; if4.a = x; if4.b = y;
      exp_q4.push_back(exp);
      t0 = cyc;
      @(negedge clk);
      if4.start = 1'b0;
      nbusy = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (if4.done) begin seen = 1; break; end
         if (if4.busy) nbusy++;
         if (poke == 1 && i == 1) begin
            if4.start = 1'b1; if4.a = 16'($urandom); if4.b = 16'($urandom);
         end
         if (poke == 1 && i == 2) if4.start = 1'b0;
         if (poke == 2) begin if4.a = ~if4.a; if4.b = ~if4.b; end
         @(negedge clk);
      end
      if (!seen) check_eq("done_timeout4", 0, 1);
      else begin
         check_eq("latency4", 64'(cyc - t0), 5);
         check_eq("busy_cycles4", 64'(nbusy), 4);
         @(negedge clk);
         check_eq("sum_hold4", 64'(if4.sum), 64'(exp[15:0]));
         check_eq("idle_after4", 64'(if4.dbg_state), 64'(ST_IDLE));
      end
   endtask

   task automatic op2(input logic s, input logic c, input logic [7:0] x, input logic [7:0] y,
                      input logic [17:0] exp);
      int t0, nbusy;
      bit seen;
      @(negedge clk);
      if2.start = 1'b1; if2.sub = s; if2.cin = c; if2.a = x; if2.b = y;
      exp_q2.push_back(exp);
      t0 = cyc;
      @(negedge clk);
      if2.start = 1'b0;
      nbusy = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (if2.done) begin seen = 1; break; end
         if (if2.busy) nbusy++;
         @(negedge clk);
      end
      if (!seen) check_eq("done_timeout2", 0, 1);
      else begin
         check_eq("latency2", 64'(cyc - t0), 3);
         check_eq("busy_cycles2", 64'(nbusy), 2);
      end
   endtask

   initial begin
      int prev, ndone;
      logic s, c;
      logic [15:0] x, y;
      logic [7:0]  x8, y8;

      rst = 1'b1;
      if4.start = 0; if4.sub = 0; if4.cin = 0; if4.a = '0; if4.b = '0;
      if2.start = 0; if2.sub = 0; if2.cin = 0; if2.a = '0; if2.b = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 64'(if4.busy), 0);
      check_eq("rst_done", 64'(if4.done), 0);
      check_eq("rst_sum",  64'(if4.sum), 0);
      check_eq("rst_cout", 64'(if4.cout), 0);
      check_eq("rst_ovf",  64'(if4.ovf), 0);
      check_eq("rst_state", 64'(if4.dbg_state), 64'(ST_IDLE));
      check_eq("rst_sum2", 64'(if2.sum), 0);
      rst = 1'b0;

      // directed add / subtract
      op4(0, 0, 0, 16'h1234, 16'h4321, {2'b00, 16'h5555});
      op4(0, 0, 1, 16'hFFFF, 16'h0000, {2'b01, 16'h0000});
      op4(0, 0, 0, 16'h7FFF, 16'h0001, {2'b10, 16'h8000});
      op4(0, 1, 1, 16'h0005, 16'h0007, {2'b00, 16'hFFFE});
      op4(0, 1, 0, 16'h8000, 16'h0001, {2'b11, 16'h7FFF});

      // start during RUN ignored; operand toggling during RUN has no effect
      op4(1, 0, 0, 16'h1111, 16'h2222, {2'b00, 16'h3333});
      op4(2, 0, 0, 16'hA5A5, 16'h0F0F, {2'b01, 16'hB4B4} ^ 18'h10000);

      // start held high: fresh capture on every DONE cycle
      @(negedge clk);
      x = 16'h0101; y = 16'h0202;
      if4.start = 1'b1; if4.sub = 0; if4.cin = 0; if4.a = x; if4.b = y;
      exp_q4.push_back(model(16, 1'b0, 1'b0, x, y));
      prev = cyc; ndone = 0;
      for (int i = 0; i < 40 && ndone < 3; i++) begin
         @(negedge clk);
         if (if4.done) begin
            ndone++;
            check_eq("b2b_gap", 64'(cyc - prev), 5);
            prev = cyc;
            if (ndone < 3) begin
               x = 16'($urandom); y = 16'($urandom);
               if4.a = x; if4.b = y;
               exp_q4.push_back(model(16, 1'b0, 1'b0, x, y));
            end else if4.start = 1'b0;
         end
      end
      if4.start = 1'b0;
      check_eq("b2b_count", 64'(ndone), 3);
      repeat (2) @(negedge clk);

      // reset mid-operation aborts without a done pulse
      @(negedge clk);
      if4.start = 1'b1; if4.sub = 0; if4.cin = 0; if4.a = 16'hFFFF; if4.b = 16'hFFFF;
      @(negedge clk);
      if4.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_busy", 64'(if4.busy), 0);
      check_eq("mid_rst_done", 64'(if4.done), 0);
      check_eq("mid_rst_sum",  64'(if4.sum), 0);
      check_eq("mid_rst_cout", 64'(if4.cout), 0);
      check_eq("mid_rst_ovf",  64'(if4.ovf), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      op4(0, 0, 0, 16'h00FF, 16'h0001, {2'b00, 16'h0100});

      // NIBBLES=2 directed
      op2(0, 0, 8'hF0, 8'h10, {2'b01, 16'h0000});
      op2(1, 0, 8'h80, 8'h01, {2'b11, 16'h007F});

      // random sweeps against the behavioural model
      for (int n = 0; n < 1000; n++) begin
         s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
         x = 16'($urandom); y = 16'($urandom);
         op4(0, s, c, x, y, model(16, s, c, x, y));
      end
      for (int n = 0; n < 300; n++) begin
         s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
         x8 = 8'($urandom); y8 = 8'($urandom);
         op2(s, c, x8, y8, model(8, s, c, {8'h0, x8}, {8'h0, y8}));
      end

      repeat (5) @(negedge clk);
      check_eq("q4_drained", 64'(exp_q4.size()), 0);
      check_eq("q2_drained", 64'(exp_q2.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
